frame_remap_engine: RTL and testbench

FRAME_REMAP_ENGINE -- requirements
Module: frame_remap_engine

---
 rtl/frame_remap_pkg.sv | 12 +
 rtl/frame_remap_addr_gen.sv | 57 +++++
 rtl/frame_remap_engine.sv | 118 +++++++++++
 tb/tb_frame_remap_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_remap_pkg.sv
// frame_remap_pkg: shared mode encodings and engine state enumeration
package frame_remap_pkg;
  typedef enum logic [2:0] {
    M_PASS     = 3'd0,
    M_SHIFT_X  = 3'd1,
    M_SHIFT_Y  = 3'd2,
    M_SCALE    = 3'd3,
    M_MIRROR_H = 3'd4,
    M_MIRROR_V = 3'd5
  } mode_t;
  typedef enum logic [2:0] {IDLE, CALC, RD_REQ, WR_REQ, FRAME_END} state_t;
endpackage

// File: rtl/frame_remap_addr_gen.sv
// frame_remap_addr_gen: maps a destination pixel to source/destination word addresses
// Ports: load (register addresses), mode/value (active transform), x/y (destination pixel),
// sel (ping/pong bases), hit (source inside frame, combinational), src_addr/dst_addr (registered).
module frame_remap_addr_gen
  import frame_remap_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int H_RES     = 1024,
  parameter int V_RES     = 768,
  parameter int MAX_SCALE = 8,
  parameter int SRC_BASE0 = 0,
  parameter int SRC_BASE1 = 2073600,
  parameter int DST_BASE0 = 4147200,
  parameter int DST_BASE1 = 6220800,
  parameter int XW        = 11,
  parameter int YW        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [2:0]        mode,
  input  logic [11:0]       value,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic              sel,
  output logic              hit,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr
);
  localparam int AW = ADDR_W + 2;
  typedef logic signed [AW-1:0] s_t;
  s_t xs, ys, vs, vc, sx, sy, src, dst;
  logic unused_hi;
  always_comb begin
    xs  = s_t'(x);
    ys  = s_t'(y);
    vs  = s_t'(signed'(value));
    vc  = (value == '0) ? s_t'(1) : (value > 12'(MAX_SCALE)) ? s_t'(MAX_SCALE) : s_t'(value);
    sx  = (mode == M_SHIFT_X) ? xs - vs : (mode == M_SCALE) ? xs * vc :
          (mode == M_MIRROR_H) ? s_t'(H_RES - 1) - xs : xs;
    sy  = (mode == M_SHIFT_Y) ? ys - vs : (mode == M_SCALE) ? ys * vc :
          (mode == M_MIRROR_V) ? s_t'(V_RES - 1) - ys : ys;
    hit = !sx[AW-1] && sx < s_t'(H_RES) && !sy[AW-1] && sy < s_t'(V_RES);
    src = (sel ? s_t'(SRC_BASE1) : s_t'(SRC_BASE0)) + sy * s_t'(H_RES) + sx;
    dst = (sel ? s_t'(DST_BASE1) : s_t'(DST_BASE0)) + ys * s_t'(H_RES) + xs;
  end
  assign unused_hi = ^{src[AW-1:ADDR_W], dst[AW-1:ADDR_W]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_addr <= '0;
      dst_addr <= '0;
    end else if (load) begin
      src_addr <= src[ADDR_W-1:0];
      dst_addr <= dst[ADDR_W-1:0];
    end
  end
endmodule

// File: rtl/frame_remap_engine.sv
// frame_remap_engine: raster frame remapper copying a transformed source frame to a destination frame
// Ports: enable/cfg_* (control and shadowed configuration), rd_* (single-beat read port),
// wr_* (single-beat write port), frame_sel/frame_done/busy/error (status).
module frame_remap_engine
  import frame_remap_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 32,
  parameter int                H_RES     = 1024,
  parameter int                V_RES     = 768,
  parameter int                MAX_SCALE = 8,
  parameter int                SRC_BASE0 = 0,
  parameter int                SRC_BASE1 = 2073600,
  parameter int                DST_BASE0 = 4147200,
  parameter int                DST_BASE1 = 6220800,
  parameter logic [DATA_W-1:0] FILL      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  input  logic [2:0]        cfg_mode,
  input  logic [11:0]       cfg_value,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [9:0]        rd_burst_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_burst_finish,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [9:0]        wr_burst_len,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_burst_finish,
  output logic              frame_sel,
  output logic              frame_done,
  output logic              busy,
  output logic              error
);
  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  state_t state, nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0] mode, sh_mode;
  logic [11:0] value, sh_value;
  logic hit, last, start, x_end, unused_ready;
  assign x_end        = x == XW'(H_RES - 1);
  assign last         = x_end && y == YW'(V_RES - 1);
  assign start        = (state == IDLE && enable) || state == FRAME_END;
  assign rd_burst_len = 10'd1;
  assign wr_burst_len = 10'd1;
  assign unused_ready = wr_ready;
  frame_remap_addr_gen #(
    .ADDR_W(ADDR_W), .H_RES(H_RES), .V_RES(V_RES), .MAX_SCALE(MAX_SCALE),
    .SRC_BASE0(SRC_BASE0), .SRC_BASE1(SRC_BASE1), .DST_BASE0(DST_BASE0), .DST_BASE1(DST_BASE1),
    .XW(XW), .YW(YW)
  ) u_addr (
    .clk(clk), .rst(rst), .load(state == CALC), .mode(mode), .value(value),
    .x(x), .y(y), .sel(frame_sel), .hit(hit), .src_addr(rd_addr), .dst_addr(wr_addr)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = enable ? CALC : IDLE;
      CALC:      nxt = hit ? RD_REQ : WR_REQ;
      RD_REQ:    nxt = rd_burst_finish ? WR_REQ : RD_REQ;
      WR_REQ:    nxt = wr_burst_finish ? (last ? FRAME_END : CALC) : WR_REQ;
      FRAME_END: nxt = enable ? CALC : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    rd_valid   = state == RD_REQ;
    wr_valid   = state == WR_REQ;
    busy       = state != IDLE;
    frame_done = state == FRAME_END;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      mode      <= M_PASS;
      value     <= '0;
      sh_mode   <= M_PASS;
      sh_value  <= '0;
      frame_sel <= 1'b0;
      wr_data   <= '0;
      error     <= 1'b0;
    end else begin
      if (cfg_valid) begin
        sh_mode  <= cfg_mode;
        sh_value <= cfg_value;
      end
      // a write landing on the frame-start cycle bypasses the shadow so it governs this frame
      if (start) begin
        mode  <= cfg_valid ? cfg_mode : sh_mode;
        value <= cfg_valid ? cfg_value : sh_value;
      end
      if (state == FRAME_END) begin
        frame_sel <= ~frame_sel;
        x         <= '0;
        y         <= '0;
      end else if (state == WR_REQ && wr_burst_finish && !last) begin
        x <= x_end ? '0 : x + 1'b1;
        y <= x_end ? y + 1'b1 : y;
      end
      if (state == CALC && !hit) wr_data <= FILL;
      if (state == RD_REQ && rd_ready) wr_data <= rd_data;
      if ((rd_burst_finish && state != RD_REQ) || (wr_burst_finish && state != WR_REQ)) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_remap_engine.sv
// tb_frame_remap_engine: scoreboard bench for frame_remap_engine on an 8x4 frame
module tb_frame_remap_engine;
  localparam logic [63:0] FILLV = 64'hF1F1_0000_0000_F1F1;
  logic clk = 0, rst = 1, enable = 0, cfg_valid = 0;
  logic [2:0] cfg_mode = 0;
  logic [11:0] cfg_value = 0;
  logic rd_valid, wr_valid, frame_sel, frame_done, busy, error;
  logic rd_ready = 0, rd_burst_finish = 0, wr_ready = 0, wr_fin_r = 0, inj_wfin = 0, wr_burst_finish;
  logic [9:0] rd_burst_len, wr_burst_len;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] rd_data = 0, wr_data;
  assign wr_burst_finish = wr_fin_r | inj_wfin;
  always #5 clk = ~clk;

  frame_remap_engine #(
    .DATA_W(64), .ADDR_W(32), .H_RES(8), .V_RES(4), .MAX_SCALE(8),
    .SRC_BASE0(0), .SRC_BASE1(32), .DST_BASE0(64), .DST_BASE1(96), .FILL(FILLV)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_value(cfg_value), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_burst_len(rd_burst_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_burst_finish(rd_burst_finish), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_burst_len(wr_burst_len), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_burst_finish(wr_burst_finish), .frame_sel(frame_sel), .frame_done(frame_done),
    .busy(busy), .error(error)
  );

  typedef struct {int dst; bit rd; int ra; logic [63:0] data;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, wcount = 0, fdone = 0;
  bit mon_on = 1, rd_hold = 0, wr_hold = 0, wr_seen = 0;
  int log_ra[7][32];
  bit log_rd[7][32];

  function automatic logic [63:0] mem(input logic [31:0] a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int k, input int mode, input int v);
    int sv;
    exp_t e;
    sv = (v < 1) ? 1 : (v > 8) ? 8 : v;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        int sx, sy;
        sx = x; sy = y;
        case (mode)
          1: sx = x - v;
          2: sy = y - v;
          3: begin sx = x * sv; sy = y * sv; end
          4: sx = 7 - x;
          5: sy = 3 - y;
          default: ;
        endcase
        e.dst  = ((k % 2) ? 96 : 64) + y * 8 + x;
        e.rd   = sx >= 0 && sx < 8 && sy >= 0 && sy < 4;
        e.ra   = ((k % 2) ? 32 : 0) + sy * 8 + sx;
        e.data = e.rd ? mem(32'(e.ra)) : FILLV;
        q.push_back(e);
      end
  endtask

  task automatic cfg(input int mode, input int v);
    cfg_valid = 1; cfg_mode = 3'(mode); cfg_value = 12'(v);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic wait_w(input int n);
    int t;
    t = 0;
    while (wcount < n && t < 3000) begin @(negedge clk); t++; end
    if (wcount < n) begin
      checks++; errors++;
      $display("FAIL timeout_writes actual=%0d expected=%0d", wcount, n);
    end
  endtask

  // memory responder: reads answer next cycle, writes are held one extra cycle
  always @(posedge clk) begin
    #1;
    rd_ready        = rd_valid && !rd_hold;
    rd_burst_finish = rd_ready;
    rd_data         = mem(rd_addr);
    wr_fin_r        = 0;
    if (!wr_valid) wr_seen = 0;
    else if (!wr_hold) begin
      if (wr_seen) begin wr_fin_r = 1; wr_seen = 0; end
      else wr_seen = 1;
    end
    wr_ready = wr_fin_r;
  end

  // monitor: pops the scoreboard on every completed write
  logic [31:0] cur_ra = 0, snap_a = 0;
  logic [63:0] snap_d = 0;
  bit cur_rd = 0, prev_wv = 0, prev_fd = 0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_on && prev_fd) chk("frame_sel", frame_sel, 64'(fdone % 2));
    if (mon_on && frame_done) begin
      chk("fd_pulse", prev_fd, 0);
      fdone++;
    end
    prev_fd = frame_done;
    if (rd_valid && rd_ready) begin cur_rd = 1; cur_ra = rd_addr; end
    if (wr_valid && !prev_wv) begin snap_a = wr_addr; snap_d = wr_data; end
    prev_wv = wr_valid;
    if (wr_valid && wr_burst_finish) begin
      if (mon_on) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%0h expected=none", wr_addr);
        end else begin
          e = q.pop_front();
          chk("wr_addr", wr_addr, 64'(e.dst));
          chk("wr_data", wr_data, e.data);
          chk("rd_issued", cur_rd, e.rd);
          if (e.rd) chk("rd_addr", cur_ra, 64'(e.ra));
          chk("wr_stable", snap_a == wr_addr && snap_d == wr_data, 1);
          if (wcount < 224) begin
            log_ra[wcount / 32][wcount % 32] = cur_ra;
            log_rd[wcount / 32][wcount % 32] = cur_rd;
          end
        end
        wcount++;
      end
      cur_rd = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int modes[6], vals[6], t;
    bit flag;
    modes = '{4, 3, 3, 1, 2, 5};
    vals  = '{0, 2, 0, 3, -1, 0};
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_frame_sel", frame_sel, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("burst_len", {rd_burst_len, wr_burst_len}, {10'd1, 10'd1});
    rst = 0;
    @(negedge clk);
    push_frame(0, 0, 0);
    enable = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        wait_w(32 * 3 + 31);
        t = 0;
        while (!frame_done && t < 100) begin @(negedge clk); t++; end
        chk("fd_seen", frame_done, 1);
      end else wait_w(32 * k + 10);
      cfg(modes[k], vals[k]);
      push_frame(k + 1, modes[k], vals[k]);
    end
    wait_w(32 * 6 + 5);
    enable = 0;
    t = 0;
    while (busy && t < 1000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("total_writes", wcount, 224);
    chk("queue_empty", q.size(), 0);
    chk("frame_count", fdone, 7);
    chk("final_sel", frame_sel, 1);
    chk("error_clean", error, 0);
    chk("pass_last", log_ra[0][31], 31);
    chk("mirh_00", log_ra[1][0], 39);
    chk("scale_11", log_ra[2][9], 18);
    chk("scale_40_fill", log_rd[2][4], 0);
    chk("scale0_clamp", log_ra[3][9], 41);
    chk("shx_fill", {log_rd[4][0], log_rd[4][1], log_rd[4][2]}, 0);
    chk("shx_x3", log_ra[4][3], 0);
    chk("shy_20", log_ra[5][2], 42);
    chk("shy_03_fill", log_rd[5][24], 0);
    chk("mirv_00", log_ra[6][0], 24);
    mon_on = 0;
    rd_hold = 1;
    enable = 1;
    t = 0;
    while (!rd_valid && t < 100) begin @(negedge clk); t++; end
    chk("rd_wait", rd_valid, 1);
    inj_wfin = 1;
    @(negedge clk);
    inj_wfin = 0;
    chk("err_set", error, 1);
    wr_hold = 1;
    rd_hold = 0;
    t = 0;
    while (!wr_valid && t < 100) begin @(negedge clk); t++; end
    chk("wr_wait", wr_valid, 1);
    chk("err_sticky", error, 1);
    #1 rst = 1;
    #1 chk("wr_drop", wr_valid, 0);
    chk("err_cleared", error, 0);
    chk("busy_rst", busy, 0);
    enable = 0;
    wr_hold = 0;
    @(negedge clk);
    rst = 0;
    flag = 0;
    repeat (10) begin @(negedge clk); if (rd_valid || wr_valid || busy) flag = 1; end
    chk("no_resume", flag, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
